// File: rtl/sprite_overlay_ctrl.sv
// Sprite overlay controller: tear-free position handshake plus a 3-stage hit/ROM/select pipeline.
// Define SPRITE_TRANSP_EN to make pixels matching TRANSP_KEY fall through to the background.
module sprite_overlay_ctrl #(
    parameter int          SPRITE_W   = 16,
    parameter int          SPRITE_H   = 16,
    parameter logic [11:0] TRANSP_KEY = 12'h000,
    localparam int         ADDR_W     = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              frame_start,
    input  logic              sprite_en,
    input  logic              pos_valid,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    output logic              pos_ready,
    output logic              pos_applied,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       sprite_pixel,
    output logic              sel,
    output logic [11:0]       sprite_colour,
    output logic              dbg_state_o
);

    // Handshake: a position transfers on a rising edge where pos_valid && pos_ready;
    // the requester must hold pos_valid/pos_x/pos_y stable until that edge.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

`ifdef SPRITE_TRANSP_EN
    localparam logic TRANSP_ACTIVE = 1'b1;
`else
    localparam logic TRANSP_ACTIVE = 1'b0;
`endif

    state_t state_q, state_d;

    logic [9:0] shadow_x_q, shadow_y_q;
    logic [9:0] act_x_q, act_y_q;
    logic       pos_applied_q;
    logic       accept, apply;

    logic [10:0]       dx, dy;
    logic              hit_s0;
    logic              hit1_q, hit2_q;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              sel_q, sel_d;
    logic [11:0]       colour_q, colour_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (pos_valid)   state_d = ST_PENDING;
            ST_PENDING: if (frame_start) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pos_ready = (state_q == ST_IDLE) && !rst;
        accept    = pos_valid && pos_ready;
        apply     = (state_q == ST_PENDING) && frame_start;
    end

    // Active position only moves on frame_start, so a frame never shows two positions.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_x_q    <= '0;
            shadow_y_q    <= '0;
            act_x_q       <= '0;
            act_y_q       <= '0;
            pos_applied_q <= 1'b0;
        end else begin
            if (accept) begin
                shadow_x_q <= pos_x;
                shadow_y_q <= pos_y;
            end
            if (apply) begin
                act_x_q <= shadow_x_q;
                act_y_q <= shadow_y_q;
            end
            pos_applied_q <= apply;
        end
    end

    // Borrow in bit 10 means the pixel lies left of / above the sprite; this also
    // prevents sprites near the right/bottom edge from wrapping to column/row 0.
    always_comb begin
        dx     = {1'b0, pixel_x} - {1'b0, act_x_q};
        dy     = {1'b0, pixel_y} - {1'b0, act_y_q};
        hit_s0 = video_on && sprite_en && !dx[10] && !dy[10] &&
                 (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));
        rom_addr_d = rom_addr_q;
        if (hit_s0) begin
            rom_addr_d = ADDR_W'({11'd0, dy} * 22'(SPRITE_W) + {11'd0, dx});
        end
    end

    always_comb begin
        sel_d    = hit2_q && !(TRANSP_ACTIVE && (sprite_pixel == TRANSP_KEY));
        colour_d = sel_d ? sprite_pixel : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            rom_addr_q <= '0;
            sel_q      <= 1'b0;
            colour_q   <= 12'h000;
        end else begin
            hit1_q     <= hit_s0;
            hit2_q     <= hit1_q;
            rom_addr_q <= rom_addr_d;
            sel_q      <= sel_d;
            colour_q   <= colour_d;
        end
    end

    assign pos_applied   = pos_applied_q;
    assign rom_addr      = rom_addr_q;
    assign sel           = sel_q;
    assign sprite_colour = colour_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sprite_overlay_ctrl.sv
// Directed table-driven bench for sprite_overlay_ctrl with a 1-cycle synchronous ROM model.
module tb_sprite_overlay_ctrl;

`ifdef SPRITE_TRANSP_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, frame_start, sprite_en;
  logic        pos_valid;
  logic [9:0]  pos_x, pos_y;
  logic        pos_ready, pos_applied;
  logic [7:0]  rom_addr;
  logic [11:0] sprite_pixel;
  logic        sel;
  logic [11:0] sprite_colour;
  logic        dbg_state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [11:0] rom_mem [256];

  sprite_overlay_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .video_on     (video_on),
    .frame_start  (frame_start),
    .sprite_en    (sprite_en),
    .pos_valid    (pos_valid),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .pos_ready    (pos_ready),
    .pos_applied  (pos_applied),
    .rom_addr     (rom_addr),
    .sprite_pixel (sprite_pixel),
    .sel          (sel),
    .sprite_colour(sprite_colour),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) sprite_pixel <= rom_mem[rom_addr];

  typedef struct {
    logic [9:0]  ax, ay;
    logic [9:0]  x, y;
    logic        von, en;
    logic [7:0]  addr;
    logic        sel;
    logic [11:0] col;
  } vec_t;

  vec_t vecs [13];
  logic [9:0] cur_x, cur_y;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one pixel sample, then check rom_addr at +1 and sel/colour at +3
  task automatic probe(input string name, input logic [9:0] x, input logic [9:0] y,
                       input logic von, input logic en, input logic [7:0] exp_addr,
                       input logic exp_sel, input logic [11:0] exp_col);
    pixel_x = x; pixel_y = y; video_on = von; sprite_en = en;
    tick();
    video_on = 1'b0;
    check({name, ".rom_addr"}, 32'(rom_addr), 32'(exp_addr));
    tick();
    tick();
    check({name, ".sel"}, 32'(sel), 32'(exp_sel));
    check({name, ".colour"}, 32'(sprite_colour), 32'(exp_col));
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!pos_ready && n < 20) begin
      tick();
      n++;
    end
    check({name, ".ready_timeout"}, 32'(pos_ready), 32'd1);
  endtask

  task automatic set_pos(input logic [9:0] x, input logic [9:0] y);
    wait_ready("set_pos");
    pos_valid = 1'b1; pos_x = x; pos_y = y;
    tick();
    pos_valid = 1'b0;
    check("set_pos.ready_low", 32'(pos_ready), 32'd0);
    check("set_pos.pending", 32'(dbg_state_o), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("set_pos.applied", 32'(pos_applied), 32'd1);
    tick();
    check("set_pos.applied_once", 32'(pos_applied), 32'd0);
    cur_x = x; cur_y = y;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom_mem[a] = 12'h800 | 12'(a);
    rom_mem[55]  = 12'h000;
    rom_mem[255] = 12'hF80;

    //            ax   ay   x    y    von en  addr sel       col
    vecs[0]  = '{10'd100, 10'd50,  10'd100, 10'd50,  1'b1, 1'b1, 8'd0,   1'b1,    12'h800};
    vecs[1]  = '{10'd100, 10'd50,  10'd115, 10'd65,  1'b1, 1'b1, 8'd255, 1'b1,    12'hF80};
    vecs[2]  = '{10'd100, 10'd50,  10'd116, 10'd65,  1'b1, 1'b1, 8'd255, 1'b0,    12'h000};
    vecs[3]  = '{10'd100, 10'd50,  10'd99,  10'd50,  1'b1, 1'b1, 8'd255, 1'b0,    12'h000};
    vecs[4]  = '{10'd100, 10'd50,  10'd107, 10'd53,  1'b0, 1'b1, 8'd255, 1'b0,    12'h000};
    vecs[5]  = '{10'd100, 10'd50,  10'd107, 10'd53,  1'b1, 1'b0, 8'd255, 1'b0,    12'h000};
    vecs[6]  = '{10'd100, 10'd50,  10'd107, 10'd53,  1'b1, 1'b1, 8'd55,  !TRANSP, 12'h000};
    vecs[7]  = '{10'd100, 10'd50,  10'd100, 10'd66,  1'b1, 1'b1, 8'd55,  1'b0,    12'h000};
    vecs[8]  = '{10'd100, 10'd50,  10'd100, 10'd49,  1'b1, 1'b1, 8'd55,  1'b0,    12'h000};
    vecs[9]  = '{10'd630, 10'd470, 10'd639, 10'd479, 1'b1, 1'b1, 8'd153, 1'b1,    12'h899};
    vecs[10] = '{10'd630, 10'd470, 10'd0,   10'd0,   1'b1, 1'b1, 8'd153, 1'b0,    12'h000};
    vecs[11] = '{10'd630, 10'd470, 10'd630, 10'd470, 1'b1, 1'b1, 8'd0,   1'b1,    12'h800};
    vecs[12] = '{10'd630, 10'd470, 10'd629, 10'd479, 1'b1, 1'b1, 8'd0,   1'b0,    12'h000};

    rst = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0; frame_start = 1'b0;
    sprite_en = 1'b0; pos_valid = 1'b0; pos_x = '0; pos_y = '0;
    cur_x = '0; cur_y = '0;

    // reset state
    tick();
    tick();
    check("rst.pos_ready", 32'(pos_ready), 32'd0);
    check("rst.sel", 32'(sel), 32'd0);
    check("rst.rom_addr", 32'(rom_addr), 32'd0);
    check("rst.pos_applied", 32'(pos_applied), 32'd0);
    check("rst.colour", 32'(sprite_colour), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst.pos_ready", 32'(pos_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst.sel_low", 32'(sel), 32'd0);
    end

    // table-driven hit/miss vectors
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].ax != cur_x || vecs[i].ay != cur_y) set_pos(vecs[i].ax, vecs[i].ay);
      probe($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].en,
            vecs[i].addr, vecs[i].sel, vecs[i].col);
    end

    // frame_start in IDLE does nothing
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("idle_fs.applied", 32'(pos_applied), 32'd0);
    check("idle_fs.ready", 32'(pos_ready), 32'd1);
    probe("idle_fs.pos_kept", 10'd630, 10'd470, 1'b1, 1'b1, 8'd0, 1'b1, 12'h800);

    // pos_valid together with frame_start in IDLE: accepted, not applied yet
    pos_valid = 1'b1; pos_x = 10'd200; pos_y = 10'd100; frame_start = 1'b1;
    tick();
    pos_valid = 1'b0; frame_start = 1'b0;
    check("same_cyc.ready", 32'(pos_ready), 32'd0);
    check("same_cyc.applied", 32'(pos_applied), 32'd0);
    probe("same_cyc.old_pos", 10'd631, 10'd470, 1'b1, 1'b1, 8'd1, 1'b1, 12'h801);
    // second request while PENDING must be ignored
    pos_valid = 1'b1; pos_x = 10'd300; pos_y = 10'd300;
    tick();
    tick();
    pos_valid = 1'b0;
    check("pend.ready_low", 32'(pos_ready), 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("pend.applied", 32'(pos_applied), 32'd1);
    tick();
    check("pend.applied_once", 32'(pos_applied), 32'd0);
    check("pend.ready_back", 32'(pos_ready), 32'd1);
    probe("pend.new_pos", 10'd200, 10'd100, 1'b1, 1'b1, 8'd0, 1'b1, 12'h800);
    probe("pend.rejected_pos", 10'd300, 10'd300, 1'b1, 1'b1, 8'd0, 1'b0, 12'h000);

    // reset while PENDING and with a hit in flight
    pos_valid = 1'b1; pos_x = 10'd20; pos_y = 10'd20;
    tick();
    pos_valid = 1'b0;
    check("rst_pend.pending", 32'(dbg_state_o), 32'd1);
    pixel_x = 10'd205; pixel_y = 10'd103; video_on = 1'b1; sprite_en = 1'b1;
    tick();
    video_on = 1'b0;
    check("rst_pend.addr_pre", 32'(rom_addr), 32'd53);
    tick();
    rst = 1'b1;
    tick();
    check("rst_pend.sel", 32'(sel), 32'd0);
    check("rst_pend.rom_addr", 32'(rom_addr), 32'd0);
    check("rst_pend.ready", 32'(pos_ready), 32'd0);
    rst = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("rst_pend.no_apply", 32'(pos_applied), 32'd0);
    tick();
    check("rst_pend.no_apply2", 32'(pos_applied), 32'd0);
    probe("rst_pend.origin", 10'd3, 10'd2, 1'b1, 1'b1, 8'd35, 1'b1, 12'h823);
    probe("rst_pend.shadow_gone", 10'd25, 10'd25, 1'b1, 1'b1, 8'd35, 1'b0, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_overlay_ctrl.md
SPRITE_OVERLAY_CTRL -- requirements
Module: sprite_overlay_ctrl

Interface
REQ-001 Parameter SPRITE_W, default 16, sprite width in pixels (power of 2).
REQ-002 Parameter SPRITE_H, default 16, sprite height in pixels (power of 2).
REQ-003 Parameter TRANSP_KEY, default 12'h000, RGB444 transparency key colour.
REQ-004 Localparam ADDR_W = $clog2(SPRITE_W*SPRITE_H).
REQ-005 clk  in  1  single system/pixel clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pixel_x, pixel_y  in  10 each  current scan coordinates from the VGA timing block.
REQ-008 video_on  in  1  visible-area flag aligned with pixel_x/pixel_y.
REQ-009 frame_start  in  1  one-cycle pulse at start of each frame (vertical blanking).
REQ-010 sprite_en  in  1  global sprite enable, sampled with pixel inputs.
REQ-011 pos_valid, pos_x[9:0], pos_y[9:0]  in  handshake request carrying new sprite top-left position.
REQ-012 pos_ready  out  1  position update accepted when pos_valid && pos_ready on a rising edge.
REQ-013 pos_applied  out  1  one-cycle pulse when shadow position is loaded into the active position.
REQ-014 rom_addr  out  ADDR_W  sprite ROM address (ROM has 1-cycle synchronous read).
REQ-015 sprite_pixel  in  12  ROM read data, valid one cycle after rom_addr.
REQ-016 sel  out  1  select to the 2:1 sprite mux (0 = background, 1 = sprite).
REQ-017 sprite_colour  out  12  sprite colour presented to the mux sprite input.

Function
REQ-018 Stage 1 (edge after sample): dx = pixel_x - act_x, dy = pixel_y - act_y in 11-bit arithmetic; hit = video_on && sprite_en && no borrow on dx/dy && dx < SPRITE_W && dy < SPRITE_H.
REQ-019 rom_addr SHALL register dy*SPRITE_W + dx on hit, else hold its previous value; latency 1 cycle.
REQ-020 sel and sprite_colour SHALL be registered with latency 3 cycles from pixel inputs; sprite_colour = sprite_pixel when sel=1, else 12'h000.
REQ-021 Sprites partly beyond x=639 or y=479 SHALL be clipped by the hit test; no wrap-around to column/row 0.
REQ-022 Position FSM states: IDLE (pos_ready=1), PENDING (pos_ready=0).
REQ-023 IDLE: pos_valid=1 -> latch pos_x/pos_y into shadow registers, go PENDING.
REQ-024 PENDING: frame_start=1 -> copy shadow into act_x/act_y, pulse pos_applied, go IDLE.
REQ-025 IDLE with pos_valid and frame_start in the same cycle: accept into shadow, go PENDING; active position unchanged until the next frame_start.
REQ-026 PENDING with pos_valid=1: no accept; requester holds until pos_ready returns.
REQ-027 frame_start in IDLE SHALL have no effect on position or pos_applied.
REQ-028 Active position change SHALL never occur mid-frame (tear-free).

Reset
REQ-029 While rst=1: state IDLE, pos_ready=0, act_x/act_y/shadow=0, rom_addr=0, sel=0, sprite_colour=0, pos_applied=0, all pipeline hit flags cleared.
REQ-030 First cycle after rst deasserts: pos_ready=1; sel stays 0 for at least 3 cycles.
REQ-031 Reset in PENDING SHALL discard the shadow position.

Configuration
REQ-032 Macro SPRITE_TRANSP_EN defined: sel=0 and sprite_colour=12'h000 when stage-2 hit but sprite_pixel == TRANSP_KEY.
REQ-033 Macro SPRITE_TRANSP_EN undefined: every hit pixel gives sel=1 regardless of sprite_pixel value; TRANSP_KEY unused.

Verification
REQ-034 After reset, pos (100,50) handshake then frame_start -> pos_applied pulses once; pixel (100,50) video_on=1 -> rom_addr=0 after 1 cycle, sel=1 after 3 cycles.
REQ-035 Active pos (100,50), pixel (115,65) -> rom_addr=255; pixel (116,65) and (99,50) -> sel=0.
REQ-036 Active pos (630,470), pixel (639,479) -> sel=1, rom_addr=9*16+9=153; pixel (0,0) -> sel=0 (no wrap).
REQ-037 pos_valid with frame_start same cycle in IDLE -> pos_ready drops, active pos unchanged; next frame_start -> applied; second pos_valid during PENDING not accepted.
REQ-038 SPRITE_TRANSP_EN, hit with sprite_pixel=12'h000 -> sel=0; sprite_pixel=12'hF80 -> sel=1, sprite_colour=12'hF80; without macro both -> sel=1.
REQ-039 rst asserted in PENDING and mid-hit -> sel=0, rom_addr=0 same edge; following frame_start -> no pos_applied, position stays (0,0).
